// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 state, operand-type and constant definitions
package fp32_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_CLASS,
    ST_CHECK,
    ST_ALIGN,
    ST_DIV,
    ST_ROUND,
    ST_RANGE,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    T_ZER,
    T_INF,
    T_NAN,
    T_NUM
  } fp_type_t;

  localparam int          BIAS        = 127;
  localparam int          EXP_MAX     = 255;
  localparam logic [30:0] INF_PATTERN = {8'hFF, 23'b0};

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational FP32 operand classifier (denormals read as zero)
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] op,
  output fp_type_t    kind
);

  logic unused_sign;
  assign unused_sign = op[31];

  always_comb begin
    kind = T_NUM;
    if (op[30:23] == 8'(EXP_MAX)) begin
      kind = (op[22:0] == 23'b0) ? T_INF : T_NAN;
    end else if (op[30:23] == 8'b0) begin
      kind = T_ZER;
    end
  end

endmodule

// File: rtl/verilog_divider.sv
// rtl/verilog_divider.sv - multi-cycle FP32 divider, restoring mantissa loop, round-to-nearest-even
// Optional status flags output enabled by defining DIV_FLAGS_EN.
module verilog_divider
  import fp32_pkg::*;
#(
  parameter logic [30:0] NAN_PATTERN = 31'h7FFFFFFF,
  parameter int          QBITS       = 25
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done
`ifdef DIV_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam int CW = $clog2(QBITS);

  state_t            state;
  logic              s1, s2;
  logic [7:0]        e1, e2;
  logic [23:0]       m1, m2;
  fp_type_t          t1, t2, rtype;
  fp_type_t          k1, k2;
  logic signed [9:0] exp_tmp;
  logic [25:0]       rem;
  logic [QBITS-1:0]  q;
  logic [CW-1:0]     cnt;
  logic [22:0]       frac;
  logic [30:0]       nres;
  logic              round_up;
  logic              carry;
`ifdef DIV_FLAGS_EN
  logic              ovf, udf;
`endif

  fp32_classify u_class1 (.op({s1, e1, m1[22:0]}), .kind(k1));
  fp32_classify u_class2 (.op({s2, e2, m2[22:0]}), .kind(k2));

  // q[0] is the guard bit; any leftover remainder acts as sticky
  assign round_up = q[0] & ((rem != 26'b0) | q[1]);
  assign carry    = round_up & (&q[QBITS-1:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_START;
      res     <= 32'b0;
      done    <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      e1      <= 8'b0;
      e2      <= 8'b0;
      m1      <= 24'b0;
      m2      <= 24'b0;
      t1      <= T_ZER;
      t2      <= T_ZER;
      rtype   <= T_ZER;
      exp_tmp <= 10'sd0;
      rem     <= 26'b0;
      q       <= '0;
      cnt     <= '0;
      frac    <= 23'b0;
      nres    <= 31'b0;
`ifdef DIV_FLAGS_EN
      flags   <= 4'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_START: begin
          done <= 1'b0;
`ifdef DIV_FLAGS_EN
          flags <= 4'b0;
`endif
          if (ready) begin
            s1    <= op1[31];
            e1    <= op1[30:23];
            m1    <= {1'b1, op1[22:0]};
            s2    <= op2[31];
            e2    <= op2[30:23];
            m2    <= {1'b1, op2[22:0]};
`ifdef DIV_FLAGS_EN
            ovf   <= 1'b0;
            udf   <= 1'b0;
`endif
            state <= ST_CLASS;
          end
        end
        ST_CLASS: begin
          t1    <= k1;
          t2    <= k2;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (t1 == T_NAN || t2 == T_NAN || (t1 == T_ZER && t2 == T_ZER) ||
              (t1 == T_INF && t2 == T_INF)) begin
            rtype <= T_NAN;
            state <= ST_FINISH;
          end else if (t1 == T_INF || t2 == T_ZER) begin
            rtype <= T_INF;
            state <= ST_FINISH;
          end else if (t1 == T_ZER || t2 == T_INF) begin
            rtype <= T_ZER;
            state <= ST_FINISH;
          end else begin
            rtype <= T_NUM;
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          // pre-shift a smaller dividend so the first quotient bit is always 1
          if (m1 < m2) begin
            rem     <= {1'b0, m1, 1'b0};
            exp_tmp <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd126;
          end else begin
            rem     <= {2'b00, m1};
            exp_tmp <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(BIAS);
          end
          q     <= '0;
          cnt   <= '0;
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (rem >= {2'b00, m2}) begin
            rem <= (rem - {2'b00, m2}) << 1;
            q   <= {q[QBITS-2:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[QBITS-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(QBITS - 1)) state <= ST_ROUND;
        end
        ST_ROUND: begin
          frac    <= q[QBITS-2:1] + {22'b0, round_up};
          exp_tmp <= exp_tmp + (carry ? 10'sd1 : 10'sd0);
          state   <= ST_RANGE;
        end
        ST_RANGE: begin
          if (exp_tmp >= 10'(EXP_MAX)) begin
            rtype <= T_INF;
`ifdef DIV_FLAGS_EN
            ovf   <= 1'b1;
`endif
          end else if (exp_tmp <= 10'sd0) begin
            rtype <= T_ZER;
`ifdef DIV_FLAGS_EN
            udf   <= 1'b1;
`endif
          end else begin
            nres <= {exp_tmp[7:0], frac};
          end
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          case (rtype)
            T_ZER:   res <= {s1 ^ s2, 31'b0};
            T_INF:   res <= {s1 ^ s2, INF_PATTERN};
            T_NAN:   res <= {s1 ^ s2, NAN_PATTERN};
            default: res <= {s1 ^ s2, nres};
          endcase
          done  <= 1'b1;
`ifdef DIV_FLAGS_EN
          flags <= {rtype == T_NAN, t1 == T_NUM && t2 == T_ZER, ovf, udf};
`endif
          state <= ST_START;
        end
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_verilog_divider.sv
// tb/tb_verilog_divider.sv - scoreboard bench for verilog_divider with arithmetic reference model
module tb_verilog_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] op1, op2;
  logic [31:0] res;
  logic        done;
`ifdef DIV_FLAGS_EN
  logic [3:0]  flags;
`endif

  verilog_divider dut (
    .clk  (clk),
    .rst  (rst),
    .ready(ready),
    .op1  (op1),
    .op2  (op2),
    .res  (res),
    .done (done)
`ifdef DIV_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    logic [3:0]  fl;
    longint      launch;
  } exp_t;

  exp_t   sbq[$];
  longint cycle = 0;
  int     total = 0;
  int     bad = 0;
  int     done_seen = 0;
  int     pushed = 0;
  logic   prev_done = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // 0 zero, 1 inf, 2 nan, 3 normal number
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'b0) ? 1 : 2;
    if (x[30:23] == 8'h00) return 0;
    return 3;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat, output logic [3:0] fl);
    int                ta, tb, kind, e;
    logic              s;
    longint unsigned   ma, mb, qq, rm, mant;
    ta = cls(a);
    tb = cls(b);
    s = a[31] ^ b[31];
    fl = 4'b0;
    lat = 3;
    r = 32'b0;
    if (ta == 2 || tb == 2 || (ta == 0 && tb == 0) || (ta == 1 && tb == 1)) kind = 2;
    else if (ta == 1 || tb == 0) kind = 1;
    else if (ta == 0 || tb == 1) kind = 0;
    else begin
      kind = 3;
      lat = 31;
      ma = {40'b0, 1'b1, a[22:0]};
      mb = {40'b0, 1'b1, b[22:0]};
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (ma >= mb) begin
        qq = (ma << 24) / mb;
        rm = (ma << 24) % mb;
      end else begin
        qq = (ma << 25) / mb;
        rm = (ma << 25) % mb;
        e = e - 1;
      end
      mant = qq >> 1;
      if ((qq & 1) != 0 && (rm != 0 || (mant & 1) != 0)) mant = mant + 1;
      if (mant >= (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        kind = 1;
        fl[1] = 1'b1;
      end else if (e <= 0) begin
        kind = 0;
        fl[0] = 1'b1;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
    case (kind)
      0: r = {s, 31'b0};
      1: r = {s, 8'hFF, 23'b0};
      2: r = {s, 31'h7FFFFFFF};
      default: ;
    endcase
    fl[3] = (kind == 2);
    fl[2] = (ta == 3 && tb == 0);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    int          c;
    c = int'($urandom_range(0, 11));
    x = $urandom;
    case (c)
      0: x[30:0] = 31'b0;
      1: x[30:0] = {8'hFF, 23'b0};
      2: x[30:23] = 8'hFF;
      3: x[30:23] = 8'h00;
      4: x[30:23] = 8'($urandom_range(1, 254));
      default: x[30:23] = 8'($urandom_range(96, 160));
    endcase
    if (c == 2 || c == 3) x[0] = 1'b1;
    return x;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rq,
                          input bit use_rq, input longint launch);
    exp_t        en;
    logic [31:0] r;
    int          lat;
    logic [3:0]  fl;
    model(a, b, r, lat, fl);
    en.res = use_rq ? rq : r;
    en.lat = lat;
    en.fl = fl;
    en.launch = launch;
    sbq.push_back(en);
    pushed++;
  endtask

  always @(negedge clk) begin
    exp_t en;
    if (rst && done === 1'b1) begin
      check("done_width", {31'b0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done res=%h required=no_done", res);
      end else begin
        en = sbq.pop_front();
        check("res", res, en.res);
        check("latency", 32'(cycle - en.launch), 32'(en.lat));
`ifdef DIV_FLAGS_EN
        check("flags", {28'b0, flags}, {28'b0, en.fl});
`endif
      end
      done_seen++;
    end
    prev_done = done;
  end

  task automatic wait_done_count(input int target);
    int n = 0;
    while (done_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (done_seen < target) begin
      total++;
      bad++;
      $display("FAIL done_timeout seen=%0d required=%0d", done_seen, target);
      sbq.delete();
      done_seen = target;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rq, input bit use_rq);
    int tgt;
    tgt = done_seen + 1;
    @(negedge clk);
    op1 = a;
    op2 = b;
    ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(a, b, rq, use_rq, cycle);
    ready = 1'b0;
    wait_done_count(tgt);
  endtask

  logic [31:0] dir_a[10] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                             32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h00400000};
  logic [31:0] dir_b[10] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h3FC00000, 32'h00000000,
                             32'h00000000, 32'hFF800000, 32'h3E800000, 32'h40000000, 32'h3F800000};
  logic [31:0] dir_r[10] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h3F2AAAAB, 32'hFF800000,
                             32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7F800000, 32'h00000000, 32'h00000000};

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] ba[3];
    logic [31:0] bb[3];
    int          tgt, n;

    rst = 1'b0;
    ready = 1'b0;
    op1 = 32'b0;
    op2 = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_res", res, 32'b0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_op(dir_a[i], dir_b[i], dir_r[i], 1'b1);

    for (int i = 0; i < 40; i++) run_op(rand_fp(), rand_fp(), 32'b0, 1'b0);

    // abort mid-division; no done pulse may follow
    @(negedge clk);
    op1 = 32'h40C00000;
    op2 = 32'h40400000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_res", res, 32'b0);
    check("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h41200000, 32'h40A00000, 32'h40000000, 1'b1);

    // ready held high across three operations
    for (int i = 0; i < 3; i++) begin
      ba[i] = rand_fp();
      bb[i] = rand_fp();
    end
    ba[0][30:23] = 8'd130;
    bb[0][30:23] = 8'd128;
    tgt = done_seen + 3;
    @(negedge clk);
    op1 = ba[0];
    op2 = bb[0];
    ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(ba[0], bb[0], 32'b0, 1'b0, cycle);
    for (int k = 1; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (done !== 1'b1 && n < 100);
      op1 = ba[k];
      op2 = bb[k];
      push_exp(ba[k], bb[k], 32'b0, 1'b0, cycle + 1);
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
    wait_done_count(tgt);

    // ready and operands toggling while busy must be ignored
    tgt = done_seen + 1;
    @(negedge clk);
    op1 = 32'h42F60000;
    op2 = 32'h41100000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'h42F60000, 32'h41100000, 32'b0, 1'b0, cycle);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ready = 1'($urandom);
      op1 = $urandom;
      op2 = $urandom;
    end
    ready = 1'b0;
    wait_done_count(tgt);

    repeat (40) @(posedge clk);
    #1;
    check("done_count", 32'(done_seen), 32'(pushed));
    check("queue_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
